// File: rtl/sxp_dpmem_if.sv
// Port bundle for the SXP dual-port RAM.
// The master side drives addresses, enables and write data; the slave side (the RAM) returns read data.
interface sxp_dpmem_if #(
    parameter int WIDTH = 32
);
    logic [31:0]      addra;
    logic [31:0]      addrb;
    logic             wea;
    logic             web;
    logic             oea;
    logic             oeb;
    logic [WIDTH-1:0] da;
    logic [WIDTH-1:0] db;
    logic [WIDTH-1:0] qa;
    logic [WIDTH-1:0] qb;

    modport master (
        output addra, addrb, wea, web, oea, oeb, da, db,
        input  qa, qb
    );

    modport slave (
        input  addra, addrb, wea, web, oea, oeb, da, db,
        output qa, qb
    );
endinterface

// File: rtl/sxp_dpmem.sv
// Synchronous true dual-port RAM shared by the SXP fetch path and scratch-pad.
// One array, two read-before-write ports, registered outputs; port B wins a same-index write collision.
module sxp_dpmem #(
    parameter int WIDTH = 32,
    parameter int SIZE  = 64
) (
    input  logic       clk,
    input  logic       reset_b,
    sxp_dpmem_if.slave bus
);
    localparam int AW = $clog2(SIZE);

    logic [WIDTH-1:0] mem [0:SIZE-1];

    logic [AW-1:0]    idx_a;
    logic [AW-1:0]    idx_b;
    logic [WIDTH-1:0] qa_d, qa_q;
    logic [WIDTH-1:0] qb_d, qb_q;
    logic             unused_addr_hi;

    // Upper address bits are dropped, so addresses wrap modulo SIZE.
    assign idx_a          = bus.addra[AW-1:0];
    assign idx_b          = bus.addrb[AW-1:0];
    assign unused_addr_hi = ^{bus.addra[31:AW], bus.addrb[31:AW]};

    always_comb begin
        qa_d = qa_q;
        qb_d = qb_q;
        if (bus.oea) begin
            qa_d = mem[idx_a];
        end
        if (bus.oeb) begin
            qb_d = mem[idx_b];
        end
    end

    // The array shares the reset branch only so writes are suppressed while reset_b is low;
    // its contents are never cleared.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            qa_q <= '0;
            qb_q <= '0;
        end else begin
            qa_q <= qa_d;
            qb_q <= qb_d;
            if (bus.wea) begin
                mem[idx_a] <= bus.da;
            end
            if (bus.web) begin
                mem[idx_b] <= bus.db;
            end
        end
    end

    assign bus.qa = qa_q;
    assign bus.qb = qb_q;

`ifndef SYNTHESIS
    task automatic mem_display();
        for (int i = 0; i < SIZE; i++) begin
            $display("mem[%0d] = %h", i, mem[i]);
        end
    endtask
`endif

endmodule

// File: tb/tb_sxp_dpmem.sv
// Bench for sxp_dpmem: directed scenarios with literal expectations, then a randomized run
// checked every cycle against a word-array reference model.
`timescale 1ns/1ps
module tb_sxp_dpmem;
    localparam int WIDTH = 32;
    localparam int SIZE  = 64;
    localparam int AW    = $clog2(SIZE);

    logic clk = 1'b0;
    logic reset_b;
    logic chk_en = 1'b0;
    int   n_cmp  = 0;
    int   n_bad  = 0;

    sxp_dpmem_if #(.WIDTH(WIDTH)) bus ();

    sxp_dpmem #(.WIDTH(WIDTH), .SIZE(SIZE)) dut (
        .clk     (clk),
        .reset_b (reset_b),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Reference model: a plain word array, reads taken before writes, B written last.
    logic [WIDTH-1:0] ref_mem [SIZE];
    logic [WIDTH-1:0] exp_qa;
    logic [WIDTH-1:0] exp_qb;

    function automatic logic [AW-1:0] wrap(input logic [31:0] a);
        return AW'(a % 32'(SIZE));
    endfunction

    always @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            exp_qa = '0;
            exp_qb = '0;
        end else begin
            if (bus.oea) exp_qa = ref_mem[wrap(bus.addra)];
            if (bus.oeb) exp_qb = ref_mem[wrap(bus.addrb)];
            if (bus.wea) ref_mem[wrap(bus.addra)] = bus.da;
            if (bus.web) ref_mem[wrap(bus.addrb)] = bus.db;
        end
    end

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            if (!$isunknown(exp_qa)) check("model_qa", bus.qa, exp_qa);
            if (!$isunknown(exp_qb)) check("model_qb", bus.qb, exp_qb);
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        bus.wea = 1'b0;
        bus.web = 1'b0;
        bus.oea = 1'b0;
        bus.oeb = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [WIDTH-1:0] img [SIZE];
    logic             rst_pulse;

    initial begin
        reset_b   = 1'b0;
        bus.addra = '0;
        bus.addrb = '0;
        bus.da    = '0;
        bus.db    = '0;
        idle();
        repeat (2) @(negedge clk);
        reset_b = 1'b1;
        step();
        check("reset_qa", bus.qa, 32'h0);
        check("reset_qb", bus.qb, 32'h0);
        chk_en = 1'b1;

        // Reset clears outputs asynchronously but leaves the array alone.
        bus.web = 1'b1; bus.addrb = 32'd0; bus.db = 32'h11111111;
        step();
        idle(); bus.oea = 1'b1; bus.oeb = 1'b1; bus.addra = 32'd0; bus.addrb = 32'd0;
        step();
        check("pre_reset_qa", bus.qa, 32'h11111111);
        @(posedge clk);
        #2 reset_b = 1'b0;
        #1;
        check("async_reset_qa", bus.qa, 32'h0);
        check("async_reset_qb", bus.qb, 32'h0);
        @(negedge clk);
        bus.wea = 1'b1; bus.addra = 32'd0; bus.da = 32'hFFFFFFFF;
        step();
        check("reset_hold_qa", bus.qa, 32'h0);
        bus.wea = 1'b0;
        reset_b = 1'b1;
        step();
        check("mem_kept_qa", bus.qa, 32'h11111111);
        check("mem_kept_qb", bus.qb, 32'h11111111);

        // One-cycle read latency.
        idle(); bus.web = 1'b1; bus.addrb = 32'd5; bus.db = 32'hDEADBEEF;
        step();
        idle(); bus.addra = 32'd5; bus.oea = 1'b1;
        #1;
        check("lat_before_edge", bus.qa, 32'h11111111);
        step();
        check("lat_qa", bus.qa, 32'hDEADBEEF);

        // Read-before-write on the same port, then across ports.
        idle(); bus.wea = 1'b1; bus.addra = 32'd3; bus.da = 32'hA5A5A5A5;
        step();
        idle(); bus.wea = 1'b1; bus.addra = 32'd3; bus.da = 32'h5A5A5A5A; bus.oea = 1'b1;
        step();
        check("rbw_old", bus.qa, 32'hA5A5A5A5);
        check("rbw_model", exp_qa, 32'hA5A5A5A5);
        idle(); bus.addra = 32'd3; bus.oea = 1'b1;
        step();
        check("rbw_new", bus.qa, 32'h5A5A5A5A);
        idle(); bus.web = 1'b1; bus.addrb = 32'd3; bus.db = 32'h77777777; bus.addra = 32'd3; bus.oea = 1'b1;
        step();
        check("xport_old", bus.qa, 32'h5A5A5A5A);
        idle(); bus.addra = 32'd3; bus.oea = 1'b1;
        step();
        check("xport_new", bus.qa, 32'h77777777);

        // Write collisions.
        idle(); bus.wea = 1'b1; bus.web = 1'b1; bus.addra = 32'd7; bus.addrb = 32'd7;
        bus.da = 32'd1; bus.db = 32'd2;
        step();
        idle(); bus.oea = 1'b1; bus.addra = 32'd7;
        step();
        check("coll_same", bus.qa, 32'd2);
        idle(); bus.wea = 1'b1; bus.web = 1'b1; bus.addra = 32'd7; bus.addrb = 32'd8;
        bus.da = 32'd1; bus.db = 32'd2;
        step();
        idle(); bus.oea = 1'b1; bus.oeb = 1'b1; bus.addra = 32'd7; bus.addrb = 32'd8;
        step();
        check("coll_diff_a", bus.qa, 32'd1);
        check("coll_diff_b", bus.qb, 32'd2);

        // Address wrap and output hold with oea low.
        idle(); bus.wea = 1'b1; bus.addra = 32'd64; bus.da = 32'hCAFE0000;
        step();
        idle(); bus.oea = 1'b1; bus.addra = 32'd0;
        step();
        check("wrap_qa", bus.qa, 32'hCAFE0000);
        idle(); bus.addra = 32'd9;
        step();
        check("oe_hold_qa", bus.qa, 32'hCAFE0000);
        check("oe_hold_model", exp_qa, 32'hCAFE0000);

        // Load a full 64-word image through port B, then stream it back through port A.
        for (int i = 0; i < SIZE; i++) begin
            img[i] = $urandom;
            idle(); bus.web = 1'b1; bus.addrb = 32'(i); bus.db = img[i];
            step();
        end
        idle();
        for (int i = 0; i < SIZE; i++) begin
            bus.oea = 1'b1; bus.addra = 32'(i);
            step();
            check("image_read", bus.qa, img[i]);
        end

        // Randomized traffic with occasional mid-cycle reset pulses.
        for (int n = 0; n < 400; n++) begin
            bus.addra = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 15));
            bus.addrb = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 15));
            bus.wea   = 1'($urandom_range(0, 1));
            bus.web   = 1'($urandom_range(0, 1));
            bus.oea   = 1'($urandom_range(0, 1));
            bus.oeb   = 1'($urandom_range(0, 1));
            bus.da    = $urandom;
            bus.db    = $urandom;
            rst_pulse = ($urandom_range(0, 49) == 0);
            if (rst_pulse) #2 reset_b = 1'b0;
            step();
            if (rst_pulse) #2 reset_b = 1'b1;
        end
        idle();
        step();

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
